alu_unit: RTL and testbench
===========================

Name: alu_unit

Overview:
- Registered 8-bit (parameterisable) integer ALU with four operations selected by a 2-bit control: add, subtract, bitwise AND, bitwise OR.
- Produces Result plus Zero and signed-Overflow flags, with one-cycle latency and a valid qualifier.
- Sits in the datapath as the basic arithmetic/logic execute stage, fed by operand registers and a decoded control field.

Parameters:
- WIDTH, 8, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands and control are valid this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- ALUControl  input  2  operation select: 00 ADD, 01 SUB, 10 AND, 11 OR
- Result  output  WIDTH  registered result
- Zero  output  1  registered; 1 when Result is all zeros
- Overflow  output  1  registered signed (two's complement) overflow flag
- out_valid  output  1  Result/flags were updated from a valid request on the previous edge

Behaviour:
- Reset (rst=1 at rising clk): Result=0, Zero=1, Overflow=0, out_valid=0. Reset dominates in_valid in the same cycle, and any request in that cycle is dropped.
- Latency: exactly 1 cycle. Inputs are sampled on the clk edge where in_valid=1. Result, Zero and Overflow update on that edge, and out_valid=1 for the following cycle.
- in_valid=0: Result, Zero and Overflow hold their previous values. out_valid=0.
- Back-to-back: a new request is accepted every cycle. There is no backpressure and no stall.
- ADD: Result = (A + B) mod 2^WIDTH. The carry-out is discarded from Result.
- SUB: Result = (A - B) mod 2^WIDTH. It is implemented as A + ~B + 1.
- AND / OR: bitwise A & B or A | B. Overflow = 0.
- Overflow for ADD: set when A[MSB] == B[MSB] and Result[MSB] != A[MSB].
- Overflow for SUB: set when A[MSB] != B[MSB] and Result[MSB] != A[MSB].
- Zero is computed from the next Result value and registered alongside it, so it is always consistent with Result, including after reset.
- Wrap-around is silent; no exception is raised. Example: 0xFF+0x01 gives 0x00 with Zero=1 and Overflow=0, since -1+1 is not a signed overflow.
- All control encodings are defined; there is no illegal state.
- The block has no state machine; it contains only the pipeline register.

Optional Feature:
- Macro: ALU_CARRY_FLAG_EN.
- When defined:
  - An extra output port Carry (1 bit, registered) exists.
  - ADD: Carry = unsigned carry-out.
  - SUB: Carry = NOT borrow, i.e. 1 when A >= B unsigned.
  - AND/OR: Carry = 0.
  - Carry resets to 0 and holds when in_valid=0.
- When undefined: the Carry port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package alu_pkg:
  - enum alu_op_e (ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11)
  - localparam ALU_DEFAULT_WIDTH=8
- One sub-module, alu_addsub: combinational WIDTH-bit adder with conditional B inversion and carry-in. It outputs sum, carry-out and signed overflow, and is shared by ADD and SUB.
- Top alu_unit holds the op mux, zero detect, valid and output registers.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, A=0x0F, B=0x03 -> Result=0x00, Zero=1, Overflow=0, out_valid=0. Deassert and the request then completes after 1 cycle.
- Basic ops, one per cycle, with A=0x0F, B=0x03:
  - ADD -> 0x12
  - SUB -> 0x0C
- Logic ops with A=0xCC, B=0xAA:
  - AND -> 0x88
  - OR -> 0xEE
  - For all four basic/logic ops: Zero=0, Overflow=0, out_valid=1 one cycle after each request.
- Wrap/overflow:
  - 0xFF+0x01 -> 0x00, Zero=1, Overflow=0 (Carry=1 with ALU_CARRY_FLAG_EN)
  - 0x7F+0x01 -> 0x80, Overflow=1
  - 0x80-0x01 -> 0x7F, Overflow=1
  - 0x03-0x03 -> 0x00, Zero=1 (Carry=1 with ALU_CARRY_FLAG_EN)
- Hold: after 0x0F+0x03, drive in_valid=0 with changing A/B/ALUControl for 3 cycles -> Result stays 0x12 and out_valid=0.
- Reset mid-stream: back-to-back requests with rst asserted in cycle 3 -> outputs return to reset values on that edge, and the cycle-3 request is never reported.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU operation encoding and default datapath width
package alu_pkg;
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;
  localparam int ALU_DEFAULT_WIDTH = 8;
endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: combinational adder/subtractor (a + ~b + 1 when sub) with carry-out and signed overflow
module alu_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  logic [WIDTH-1:0] bx;
  assign bx = sub ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
  assign ovf = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/alu_unit.sv
// alu_unit: registered add/sub/and/or ALU with Zero/Overflow flags; Carry output when ALU_CARRY_FLAG_EN is defined
module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       ALUControl,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic             out_valid
`ifdef ALU_CARRY_FLAG_EN
  ,
  output logic             Carry
`endif
);
  alu_op_e          op;
  logic [WIDTH-1:0] sum, res_n;
  logic             cy, ovf, ovf_n, cy_n;
  assign op = alu_op_e'(ALUControl);
  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a(A),
    .b(B),
    .sub(op == ALU_SUB),
    .sum(sum),
    .cout(cy),
    .ovf(ovf)
  );
  always_comb begin
    res_n = op == ALU_AND ? A & B : op == ALU_OR ? A | B : sum;
    ovf_n = op[1] ? 1'b0 : ovf;
    cy_n  = op[1] ? 1'b0 : cy;
  end
`ifndef ALU_CARRY_FLAG_EN
  logic unused;
  assign unused = cy_n;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      Result    <= '0;
      Zero      <= 1'b1;
      Overflow  <= 1'b0;
      out_valid <= 1'b0;
`ifdef ALU_CARRY_FLAG_EN
      Carry     <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Result   <= res_n;
        Zero     <= res_n == '0;
        Overflow <= ovf_n;
`ifdef ALU_CARRY_FLAG_EN
        Carry    <= cy_n;
`endif
      end
    end
  end
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: randomized scoreboard bench for alu_unit against an integer-arithmetic reference model
module tb_alu_unit;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst, in_valid, Zero, Overflow, out_valid;
  logic [W-1:0] A, B, Result;
  logic [1:0]   ALUControl;
`ifdef ALU_CARRY_FLAG_EN
  logic         Carry;
`endif
  typedef struct {
    logic [W-1:0] r;
    logic         z;
    logic         v;
    logic         c;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  alu_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .A(A),
    .B(B),
    .ALUControl(ALUControl),
    .Result(Result),
    .Zero(Zero),
    .Overflow(Overflow),
    .out_valid(out_valid)
`ifdef ALU_CARRY_FLAG_EN
    ,
    .Carry(Carry)
`endif
  );
  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] op);
    exp_t m;
    int ua = a;
    int ub = b;
    int sa = $signed(a);
    int sb = $signed(b);
    int r = 0;
    int s = 0;
    m.c = 1'b0;
    case (op)
      2'd0: begin r = ua + ub; s = sa + sb; m.c = r >= (1 << W); end
      2'd1: begin r = ua - ub; s = sa - sb; m.c = ua >= ub; end
      2'd2: r = ua & ub;
      default: r = ua | ub;
    endcase
    m.r = r[W-1:0];
    m.z = m.r == 0;
    m.v = s > (1 << (W - 1)) - 1 || s < -(1 << (W - 1));
    return m;
  endfunction
  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(logic r, logic v, logic [W-1:0] a, logic [W-1:0] b, logic [1:0] op);
    @(negedge clk);
    rst = r;
    in_valid = v;
    A = a;
    B = b;
    ALUControl = op;
    if (v && !r) q.push_back(model(a, b, op));
  endtask
  task automatic drive_rand(logic r, logic v);
    logic [W-1:0] a = W'($urandom);
    logic [W-1:0] b = W'($urandom);
    logic [1:0] op = 2'($urandom);
    drive(r, v, a, b, op);
  endtask
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_out_valid: got 1 expected 0 at %0t", $time);
      end else begin
        e = q.pop_front();
        cmp("result", 32'(Result), 32'(e.r));
        cmp("zero", 32'(Zero), 32'(e.z));
        cmp("overflow", 32'(Overflow), 32'(e.v));
`ifdef ALU_CARRY_FLAG_EN
        cmp("carry", 32'(Carry), 32'(e.c));
`endif
      end
    end
  end
  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    A = 8'h0F;
    B = 8'h03;
    ALUControl = 2'd0;
    repeat (2) @(negedge clk);
    cmp("reset_result", 32'(Result), 32'h0);
    cmp("reset_zero", 32'(Zero), 32'h1);
    cmp("reset_overflow", 32'(Overflow), 32'h0);
    cmp("reset_out_valid", 32'(out_valid), 32'h0);
`ifdef ALU_CARRY_FLAG_EN
    cmp("reset_carry", 32'(Carry), 32'h0);
`endif
    drive(0, 1, 8'h0F, 8'h03, 2'd0);
    drive(0, 1, 8'h0F, 8'h03, 2'd1);
    drive(0, 1, 8'hCC, 8'hAA, 2'd2);
    drive(0, 1, 8'hCC, 8'hAA, 2'd3);
    drive(0, 1, 8'hFF, 8'h01, 2'd0);
    drive(0, 1, 8'h7F, 8'h01, 2'd0);
    drive(0, 1, 8'h80, 8'h01, 2'd1);
    drive(0, 1, 8'h03, 8'h03, 2'd1);
    drive(0, 1, 8'h0F, 8'h03, 2'd0);
    for (int i = 0; i < 4; i++) begin
      drive_rand(0, 0);
      if (i > 0) begin
        cmp("hold_result", 32'(Result), 32'h12);
        cmp("hold_out_valid", 32'(out_valid), 32'h0);
      end
    end
    drive_rand(0, 1);
    drive_rand(0, 1);
    drive_rand(1, 1);
    drive_rand(0, 0);
    cmp("midreset_result", 32'(Result), 32'h0);
    cmp("midreset_zero", 32'(Zero), 32'h1);
    cmp("midreset_out_valid", 32'(out_valid), 32'h0);
    for (int i = 0; i < 300; i++) drive_rand(0, $urandom_range(0, 3) != 0);
    drive_rand(0, 0);
    drive_rand(0, 0);
    cmp("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
